// File: rtl/therm_adc_sampler.sv
// Periodic SPI reader for a 12-bit thermistor ADC: frames a conversion every
// SAMPLE_PERIOD clocks and publishes the mean of 2^AVG_LOG2 conversions.
module therm_adc_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] v_therm,
    output logic        v_valid,
    output logic        busy
);

    localparam int unsigned FRAME_LEN = 32 * CLK_DIV;
    localparam int unsigned PCNT_MAX  = (SAMPLE_PERIOD > FRAME_LEN + 1) ? SAMPLE_PERIOD : FRAME_LEN + 1;
    localparam int unsigned PW        = $clog2(PCNT_MAX + 1);
    localparam int unsigned DW        = $clog2(CLK_DIV);
    localparam int unsigned AW        = 12 + AVG_LOG2;
    localparam int unsigned CW        = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CONV_LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, WAIT, SETUP, SHIFT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   div_cnt;
    logic            phase;
    logic [3:0]      bit_cnt;
    logic [PW-1:0]   period_cnt;
    logic [11:0]     shreg;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   conv_cnt;
    logic            en_lost;
    logic            avg_ready;
    logic            div_done;
    logic            frame_start;
    logic            hold_exit;
    logic            in_frame;

    assign div_done    = (div_cnt == DW'(CLK_DIV - 1));
    assign in_frame    = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign frame_start = (state_nxt == SETUP) && ((state == IDLE) || (state == WAIT));
    assign hold_exit   = (state == HOLD) && div_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SETUP;
            WAIT: begin
                if (!enable)                                 state_nxt = IDLE;
                else if (period_cnt >= PW'(SAMPLE_PERIOD))   state_nxt = SETUP;
            end
            SETUP:   if (div_done) state_nxt = SHIFT;
            SHIFT:   if (div_done && phase && (bit_cnt == 4'd14)) state_nxt = HOLD;
            HOLD:    if (div_done) state_nxt = (enable && !en_lost) ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adc_cs_n = 1'b1;
        adc_sclk = 1'b0;
        case (state)
            SETUP, HOLD: adc_cs_n = 1'b0;
            SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = phase;
            end
            default: ;
        endcase
        busy = ~adc_cs_n;
    end

    // period_cnt holds the number of clks elapsed since the last adc_cs_n fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            div_cnt    <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            en_lost    <= 1'b0;
        end else begin
            if (frame_start)                     period_cnt <= PW'(1);
            else if (period_cnt != PW'(PCNT_MAX)) period_cnt <= period_cnt + PW'(1);

            if (in_frame) div_cnt <= div_done ? '0 : div_cnt + DW'(1);
            else          div_cnt <= '0;

            if (state != SHIFT)  phase <= 1'b0;
            else if (div_done)   phase <= ~phase;

            if (state == SETUP)                          bit_cnt <= '0;
            else if ((state == SHIFT) && div_done && phase) bit_cnt <= bit_cnt + 4'd1;

            // 15 bits shift through a 12-bit register, so the 3 leading bits fall off
            if ((state == SHIFT) && div_done && !phase) shreg <= {shreg[10:0], adc_miso};

            if (frame_start)              en_lost <= 1'b0;
            else if (in_frame && !enable) en_lost <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            conv_cnt  <= '0;
            avg_ready <= 1'b0;
            v_therm   <= '0;
            v_valid   <= 1'b0;
        end else begin
            v_valid <= avg_ready;
            if (avg_ready) v_therm <= 12'(acc >> AVG_LOG2);

            if (hold_exit) begin
                if (enable && !en_lost) begin
                    acc       <= acc + AW'(shreg);
                    conv_cnt  <= conv_cnt + CW'(1);
                    avg_ready <= (conv_cnt == CONV_LAST);
                end else begin
                    acc       <= '0;
                    conv_cnt  <= '0;
                    avg_ready <= 1'b0;
                end
            end else begin
                avg_ready <= 1'b0;
                if (avg_ready || ((state == WAIT) && !enable)) begin
                    acc      <= '0;
                    conv_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_therm_adc_sampler.sv
// Scoreboard bench: ADC models serve queued codes, expected averages are
// queued at stimulus time and popped by monitors on each v_valid.
module tb_therm_adc_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    logic        rst_n;
    logic        en_a, miso_a, cs_a, sclk_a, vv_a, busy_a;
    logic [11:0] vt_a;
    logic        en_b, miso_b, cs_b, sclk_b, vv_b, busy_b;
    logic [11:0] vt_b;

    therm_adc_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(1000), .AVG_LOG2(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .adc_miso(miso_a),
        .adc_cs_n(cs_a), .adc_sclk(sclk_a), .v_therm(vt_a), .v_valid(vv_a), .busy(busy_a)
    );

    therm_adc_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(50), .AVG_LOG2(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .adc_miso(miso_b),
        .adc_cs_n(cs_b), .adc_sclk(sclk_b), .v_therm(vt_b), .v_valid(vv_b), .busy(busy_b)
    );

    // ---------------- ADC models: 3 junk bits then 12-bit code, MSB first
    int unsigned code_qa[$], code_qb[$];
    logic [14:0] bits_a, bits_b;
    int          bi_a = 0, bi_b = 0;

    always @(negedge cs_a) begin
        logic [11:0] c;
        c = (code_qa.size() > 0) ? 12'(code_qa.pop_front()) : 12'($urandom);
        bits_a = {3'($urandom), c};
        bi_a   = 0;
        miso_a = bits_a[14];
    end
    always @(negedge sclk_a) if (!cs_a && bi_a < 14) begin
        bi_a++;
        miso_a = bits_a[14 - bi_a];
    end

    always @(negedge cs_b) begin
        logic [11:0] c;
        c = (code_qb.size() > 0) ? 12'(code_qb.pop_front()) : 12'($urandom);
        bits_b = {3'($urandom), c};
        bi_b   = 0;
        miso_b = bits_b[14];
    end
    always @(negedge sclk_b) if (!cs_b && bi_b < 14) begin
        bi_b++;
        miso_b = bits_b[14 - bi_b];
    end

    // ---------------- reference model: mean of 4 codes, truncated
    int unsigned exp_qa[$], exp_qb[$];

    task automatic push_group(input bit to_b, input bit with_exp,
                              input int unsigned c0, c1, c2, c3);
        int unsigned c[4];
        int unsigned sum;
        c = '{c0, c1, c2, c3};
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (to_b) code_qb.push_back(c[i]); else code_qa.push_back(c[i]);
            sum += c[i];
        end
        if (with_exp) begin
            if (to_b) exp_qb.push_back(sum / 4); else exp_qa.push_back(sum / 4);
        end
    endtask

    task automatic push_random(input bit to_b, input bit with_exp);
        push_group(to_b, with_exp, $urandom_range(0, 4095), $urandom_range(0, 4095),
                   $urandom_range(0, 4095), $urandom_range(0, 4095));
    endtask

    // ---------------- monitors
    logic [11:0] held_a = '0, held_b = '0;
    logic        pvv_a = 1'b0, pvv_b = 1'b0;
    logic        pcs_a = 1'b1, pcs_b = 1'b1;
    int unsigned valid_cnt_a = 0, valid_cnt_b = 0;
    int unsigned fall_cnt_a = 0, fall_cnt_b = 0;
    int unsigned low_t_a = 0, low_t_b = 0, rise_t_b = 0;
    bit          had_rise_b = 1'b0;
    int unsigned fall_t_a[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            held_a = '0; held_b = '0; pvv_a = 1'b0; pvv_b = 1'b0;
        end else begin
            if (vv_a) begin
                valid_cnt_a++;
                if (exp_qa.size() == 0) chk("unexpected_vvalid_a", vv_a, 0);
                else begin
                    held_a = 12'(exp_qa.pop_front());
                    chk("v_therm_a", vt_a, held_a);
                end
                chk("vvalid_width_a", pvv_a, 0);
            end else chk("v_therm_hold_a", vt_a, held_a);
            pvv_a = vv_a;

            if (vv_b) begin
                valid_cnt_b++;
                if (exp_qb.size() == 0) chk("unexpected_vvalid_b", vv_b, 0);
                else begin
                    held_b = 12'(exp_qb.pop_front());
                    chk("v_therm_b", vt_b, held_b);
                end
                chk("vvalid_width_b", pvv_b, 0);
            end else chk("v_therm_hold_b", vt_b, held_b);
            pvv_b = vv_b;
        end

        chk("busy_a", busy_a, !cs_a);
        chk("busy_b", busy_b, !cs_b);
        if (cs_a) chk("sclk_idle_a", sclk_a, 0);
        if (cs_b) chk("sclk_idle_b", sclk_b, 0);

        if (pcs_a && !cs_a) begin fall_cnt_a++; low_t_a = cyc; fall_t_a.push_back(cyc); end
        if (!pcs_a && cs_a && rst_n) chk("cs_low_width_a", cyc - low_t_a, 128);
        pcs_a = cs_a;

        if (pcs_b && !cs_b) begin
            fall_cnt_b++; low_t_b = cyc;
            if (had_rise_b) chk("cs_gap_b", cyc - rise_t_b, 1);
        end
        if (!pcs_b && cs_b && rst_n) begin
            chk("cs_low_width_b", cyc - low_t_b, 128);
            rise_t_b = cyc; had_rise_b = 1'b1;
        end
        pcs_b = cs_b;
    end

    // ---------------- bounded waits
    task automatic wait_valid_a(input int unsigned target);
        int unsigned t = 0;
        while (valid_cnt_a < target && t < 20000) begin @(negedge clk); t++; end
        chk("vvalid_count_a", valid_cnt_a, target);
    endtask

    task automatic wait_falls_a(input int unsigned target);
        int unsigned t = 0;
        while (fall_cnt_a < target && t < 5000) begin @(negedge clk); t++; end
        chk("cs_fall_count_a", fall_cnt_a, target);
    endtask

    task automatic wait_cs_high_a();
        int unsigned t = 0;
        while (!cs_a && t < 500) begin @(negedge clk); t++; end
        chk("cs_frame_end_a", cs_a, 1);
    endtask

    // ---------------- stimulus
    initial begin
        int unsigned f0, nv;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; miso_a = 1'b0; miso_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_v_therm", vt_a, 0);
        chk("rst_v_valid", vv_a, 0);
        chk("rst_busy", busy_a, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_frame_without_enable", fall_cnt_a + fall_cnt_b, 0);

        // back-to-back frames with a short period
        push_random(1'b1, 1'b1);
        push_random(1'b1, 1'b1);
        en_b = 1'b1;
        begin
            int unsigned t = 0;
            while (valid_cnt_b < 2 && t < 3000) begin @(negedge clk); t++; end
        end
        en_b = 1'b0;
        chk("vvalid_count_b", valid_cnt_b, 2);
        chk("frames_b", fall_cnt_b, 9);

        // fixed code, truncation, full scale; 1000-clk frame spacing
        push_group(1'b0, 1'b1, 12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C);
        push_group(1'b0, 1'b1, 12'h000, 12'h001, 12'h002, 12'h004);
        push_group(1'b0, 1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        fall_t_a.delete();
        en_a = 1'b1;
        wait_valid_a(3);
        en_a = 1'b0;
        for (int i = 1; i < fall_t_a.size(); i++)
            chk("cs_period_a", fall_t_a[i] - fall_t_a[i-1], 1000);
        repeat (5) @(negedge clk);

        // enable dropped in WAIT clears the partial average
        push_random(1'b0, 1'b0);
        push_random(1'b0, 1'b0);
        f0 = fall_cnt_a;
        en_a = 1'b1;
        wait_falls_a(f0 + 2);
        wait_cs_high_a();
        repeat (10) @(negedge clk);
        en_a = 1'b0;
        repeat (1500) @(negedge clk);
        chk("idle_after_wait_drop", fall_cnt_a, f0 + 2);
        code_qa.delete();
        nv = valid_cnt_a;
        push_random(1'b0, 1'b1);
        f0 = fall_cnt_a;
        en_a = 1'b1;
        wait_valid_a(nv + 1);
        en_a = 1'b0;
        chk("frames_per_avg_a", fall_cnt_a - f0, 4);
        repeat (5) @(negedge clk);

        // enable dropped during the 2nd frame
        push_random(1'b0, 1'b0);
        f0 = fall_cnt_a;
        en_a = 1'b1;
        wait_falls_a(f0 + 2);
        repeat (10) @(negedge clk);
        en_a = 1'b0;
        wait_cs_high_a();
        repeat (1200) @(negedge clk);
        chk("idle_after_frame_drop", fall_cnt_a, f0 + 2);
        code_qa.delete();
        nv = valid_cnt_a;
        push_random(1'b0, 1'b1);
        f0 = fall_cnt_a;
        en_a = 1'b1;
        wait_valid_a(nv + 1);
        en_a = 1'b0;
        chk("frames_after_reenable", fall_cnt_a - f0, 4);
        repeat (5) @(negedge clk);

        // reset pulsed mid-SHIFT
        push_random(1'b0, 1'b0);
        f0 = fall_cnt_a;
        en_a = 1'b1;
        wait_falls_a(f0 + 2);
        repeat (20) @(negedge clk);
        chk("pre_reset_in_frame", cs_a, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", cs_a, 1);
        chk("midrst_sclk", sclk_a, 0);
        chk("midrst_v_therm", vt_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_v_valid", vv_a, 0);
        en_a = 1'b0;
        code_qa.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        f0 = fall_cnt_a;
        repeat (300) @(negedge clk);
        chk("no_frame_after_reset", fall_cnt_a, f0);
        nv = valid_cnt_a;
        push_random(1'b0, 1'b1);
        en_a = 1'b1;
        wait_valid_a(nv + 1);
        en_a = 1'b0;
        chk("frames_after_reset", fall_cnt_a - f0, 4);
        repeat (20) @(negedge clk);
        chk("scoreboard_drained_a", exp_qa.size(), 0);
        chk("scoreboard_drained_b", exp_qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
